id_stage: RTL and testbench

RV32I decode stage, directly upstream of the register file and feeding the EX stage.
- Takes the IF/ID instruction and drives the regfile read ports (re1/raddr1, re2/raddr2).
- Forwards results from EX and MEM, detects load-use hazards, and decodes immediates and ALU controls.
- Registers all results into the ID/EX pipeline register, with stall and flush control.

---
 rtl/id_stage.sv | 238 +++++++++++++++++++++++
 tb/tb_id_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// RV32I decode stage: drives the register-file read ports, applies the EX/MEM bypasses,
// detects load-use hazards and registers the decoded instruction into the ID/EX register.
module id_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic              clk_i,
   input  logic              rst_ni,

   input  logic              if_valid_i,
   input  logic [DATA_W-1:0] if_pc_i,
   input  logic [31:0]       if_inst_i,
   output logic              id_ready_o,

   output logic              re1_o,
   output logic [REG_AW-1:0] raddr1_o,
   input  logic [DATA_W-1:0] rdata1_i,
   output logic              re2_o,
   output logic [REG_AW-1:0] raddr2_o,
   input  logic [DATA_W-1:0] rdata2_i,

   input  logic              ex_fwd_we_i,
   input  logic [REG_AW-1:0] ex_fwd_waddr_i,
   input  logic [DATA_W-1:0] ex_fwd_wdata_i,
   input  logic              ex_fwd_is_load_i,
   input  logic              mem_fwd_we_i,
   input  logic [REG_AW-1:0] mem_fwd_waddr_i,
   input  logic [DATA_W-1:0] mem_fwd_wdata_i,

   input  logic              ex_stall_i,
   input  logic              flush_i,

   output logic              ex_valid_o,
   output logic [DATA_W-1:0] ex_pc_o,
   output logic [DATA_W-1:0] ex_op1_o,
   output logic [DATA_W-1:0] ex_op2_o,
   output logic [DATA_W-1:0] ex_imm_o,
   output logic [DATA_W-1:0] ex_store_data_o,
   output logic [REG_AW-1:0] ex_rd_o,
   output logic              ex_rd_we_o,
   output logic [3:0]        ex_alu_op_o,
   output logic [2:0]        ex_funct3_o,
   output logic              ex_is_load_o,
   output logic              ex_is_store_o,
   output logic              ex_is_branch_o,
   output logic              ex_is_jal_o,
   output logic              ex_is_jalr_o,
   output logic              ex_illegal_o
);

   localparam logic [6:0] OpcLui    = 7'h37;
   localparam logic [6:0] OpcAuipc  = 7'h17;
   localparam logic [6:0] OpcJal    = 7'h6F;
   localparam logic [6:0] OpcJalr   = 7'h67;
   localparam logic [6:0] OpcBranch = 7'h63;
   localparam logic [6:0] OpcLoad   = 7'h03;
   localparam logic [6:0] OpcStore  = 7'h23;
   localparam logic [6:0] OpcOpImm  = 7'h13;
   localparam logic [6:0] OpcOp     = 7'h33;

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] store_data;
      logic [REG_AW-1:0] rd;
      logic              rd_we;
      logic [3:0]        alu_op;
      logic [2:0]        funct3;
      logic              is_load;
      logic              is_store;
      logic              is_branch;
      logic              is_jal;
      logic              is_jalr;
      logic              illegal;
   } idex_t;

   idex_t idex_q, idex_d, dec;

   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic [REG_AW-1:0] rd;
   logic              is_lui, is_auipc, is_jal, is_jalr, is_branch;
   logic              is_load, is_store, is_opimm, is_op, is_illegal;
   logic [31:0]       imm32;
   logic [DATA_W-1:0] imm;
   logic [DATA_W-1:0] rs1_val, rs2_val;
   logic              hazard;

   assign opcode = if_inst_i[6:0];
   assign funct3 = if_inst_i[14:12];
   assign rd     = REG_AW'(if_inst_i[11:7]);

   assign is_lui     = (opcode == OpcLui);
   assign is_auipc   = (opcode == OpcAuipc);
   assign is_jal     = (opcode == OpcJal);
   assign is_jalr    = (opcode == OpcJalr);
   assign is_branch  = (opcode == OpcBranch);
   assign is_load    = (opcode == OpcLoad);
   assign is_store   = (opcode == OpcStore);
   assign is_opimm   = (opcode == OpcOpImm);
   assign is_op      = (opcode == OpcOp);
   assign is_illegal = ~(is_lui | is_auipc | is_jal | is_jalr | is_branch |
                         is_load | is_store | is_opimm | is_op);

   assign re1_o    = if_valid_i & (is_jalr | is_branch | is_load | is_store | is_opimm | is_op);
   assign re2_o    = if_valid_i & (is_branch | is_store | is_op);
   assign raddr1_o = REG_AW'(if_inst_i[19:15]);
   assign raddr2_o = REG_AW'(if_inst_i[24:20]);

   always_comb begin
      imm32 = '0;
      if (is_lui || is_auipc) begin
         imm32 = {if_inst_i[31:12], 12'b0};
      end else if (is_jal) begin
         imm32 = {{12{if_inst_i[31]}}, if_inst_i[19:12], if_inst_i[20], if_inst_i[30:21], 1'b0};
      end else if (is_jalr || is_load || is_opimm) begin
         imm32 = {{20{if_inst_i[31]}}, if_inst_i[31:20]};
      end else if (is_store) begin
         imm32 = {{20{if_inst_i[31]}}, if_inst_i[31:25], if_inst_i[11:7]};
      end else if (is_branch) begin
         imm32 = {{20{if_inst_i[31]}}, if_inst_i[7], if_inst_i[30:25], if_inst_i[11:8], 1'b0};
      end
   end

   assign imm = DATA_W'($signed(imm32));

   // Bypass: x0 and disabled ports read as zero; EX is younger than MEM so it wins.
   always_comb begin
      rs1_val = rdata1_i;
      if (!re1_o || raddr1_o == '0) begin
         rs1_val = '0;
      end else if (ex_fwd_we_i && ex_fwd_waddr_i == raddr1_o) begin
         rs1_val = ex_fwd_wdata_i;
      end else if (mem_fwd_we_i && mem_fwd_waddr_i == raddr1_o) begin
         rs1_val = mem_fwd_wdata_i;
      end
   end

   always_comb begin
      rs2_val = rdata2_i;
      if (!re2_o || raddr2_o == '0) begin
         rs2_val = '0;
      end else if (ex_fwd_we_i && ex_fwd_waddr_i == raddr2_o) begin
         rs2_val = ex_fwd_wdata_i;
      end else if (mem_fwd_we_i && mem_fwd_waddr_i == raddr2_o) begin
         rs2_val = mem_fwd_wdata_i;
      end
   end

   assign hazard = ex_fwd_is_load_i & ex_fwd_we_i & (ex_fwd_waddr_i != '0) &
                   ((re1_o & (ex_fwd_waddr_i == raddr1_o)) |
                    (re2_o & (ex_fwd_waddr_i == raddr2_o)));

   always_comb begin
      dec            = '0;
      dec.valid      = 1'b1;
      dec.pc         = if_pc_i;
      dec.imm        = imm;
      dec.store_data = rs2_val;
      dec.rd         = rd;
      dec.funct3     = funct3;
      dec.is_load    = is_load;
      dec.is_store   = is_store;
      dec.is_branch  = is_branch;
      dec.is_jal     = is_jal;
      dec.is_jalr    = is_jalr;
      dec.illegal    = is_illegal;
      dec.rd_we      = (is_lui | is_auipc | is_jal | is_jalr | is_load | is_opimm | is_op) &
                       (rd != '0);

      if (is_lui) begin
         dec.op1 = '0;
      end else if (is_auipc || is_jal) begin
         dec.op1 = if_pc_i;
      end else begin
         dec.op1 = rs1_val;
      end

      if (is_op || is_branch) begin
         dec.op2 = rs2_val;
      end else if (is_jal || is_jalr) begin
         dec.op2 = DATA_W'(4);
      end else begin
         dec.op2 = imm;
      end

      if (is_op) begin
         dec.alu_op = {if_inst_i[30], funct3};
      end else if (is_opimm) begin
         dec.alu_op = {(funct3 == 3'b101) & if_inst_i[30], funct3};
      end
   end

   // Flush beats stall so a redirect can kill a held instruction.
   always_comb begin
      idex_d = idex_q;
      if (flush_i) begin
         idex_d = '0;
      end else if (ex_stall_i) begin
         idex_d = idex_q;
      end else if (hazard || !if_valid_i) begin
         idex_d = '0;
      end else begin
         idex_d = dec;
      end
   end

   assign id_ready_o = rst_ni & (flush_i | (~ex_stall_i & ~hazard));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idex_q <= '0;
      end else begin
         idex_q <= idex_d;
      end
   end

   assign ex_valid_o      = idex_q.valid;
   assign ex_pc_o         = idex_q.pc;
   assign ex_op1_o        = idex_q.op1;
   assign ex_op2_o        = idex_q.op2;
   assign ex_imm_o        = idex_q.imm;
   assign ex_store_data_o = idex_q.store_data;
   assign ex_rd_o         = idex_q.rd;
   assign ex_rd_we_o      = idex_q.rd_we;
   assign ex_alu_op_o     = idex_q.alu_op;
   assign ex_funct3_o     = idex_q.funct3;
   assign ex_is_load_o    = idex_q.is_load;
   assign ex_is_store_o   = idex_q.is_store;
   assign ex_is_branch_o  = idex_q.is_branch;
   assign ex_is_jal_o     = idex_q.is_jal;
   assign ex_is_jalr_o    = idex_q.is_jalr;
   assign ex_illegal_o    = idex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: hand-decoded RV32I vectors with expected ID/EX contents.
module tb_id_stage;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_AW = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              if_valid;
   logic [DATA_W-1:0] if_pc;
   logic [31:0]       if_inst;
   logic              id_ready;
   logic              re1, re2;
   logic [REG_AW-1:0] raddr1, raddr2;
   logic [DATA_W-1:0] rdata1, rdata2;
   logic              ex_fwd_we, ex_fwd_is_load, mem_fwd_we;
   logic [REG_AW-1:0] ex_fwd_waddr, mem_fwd_waddr;
   logic [DATA_W-1:0] ex_fwd_wdata, mem_fwd_wdata;
   logic              ex_stall, flush;
   logic              ex_valid, ex_rd_we;
   logic [DATA_W-1:0] ex_pc, ex_op1, ex_op2, ex_imm, ex_store_data;
   logic [REG_AW-1:0] ex_rd;
   logic [3:0]        ex_alu_op;
   logic [2:0]        ex_funct3;
   logic              ex_is_load, ex_is_store, ex_is_branch, ex_is_jal, ex_is_jalr, ex_illegal;

   int n_checks = 0;
   int n_errs   = 0;

   id_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .if_valid_i(if_valid), .if_pc_i(if_pc), .if_inst_i(if_inst), .id_ready_o(id_ready),
      .re1_o(re1), .raddr1_o(raddr1), .rdata1_i(rdata1),
      .re2_o(re2), .raddr2_o(raddr2), .rdata2_i(rdata2),
      .ex_fwd_we_i(ex_fwd_we), .ex_fwd_waddr_i(ex_fwd_waddr), .ex_fwd_wdata_i(ex_fwd_wdata),
      .ex_fwd_is_load_i(ex_fwd_is_load),
      .mem_fwd_we_i(mem_fwd_we), .mem_fwd_waddr_i(mem_fwd_waddr),
      .mem_fwd_wdata_i(mem_fwd_wdata),
      .ex_stall_i(ex_stall), .flush_i(flush),
      .ex_valid_o(ex_valid), .ex_pc_o(ex_pc), .ex_op1_o(ex_op1), .ex_op2_o(ex_op2),
      .ex_imm_o(ex_imm), .ex_store_data_o(ex_store_data), .ex_rd_o(ex_rd),
      .ex_rd_we_o(ex_rd_we), .ex_alu_op_o(ex_alu_op), .ex_funct3_o(ex_funct3),
      .ex_is_load_o(ex_is_load), .ex_is_store_o(ex_is_store), .ex_is_branch_o(ex_is_branch),
      .ex_is_jal_o(ex_is_jal), .ex_is_jalr_o(ex_is_jalr), .ex_illegal_o(ex_illegal)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic quiet_fwd();
      ex_fwd_we = 1'b0; ex_fwd_waddr = '0; ex_fwd_wdata = '0; ex_fwd_is_load = 1'b0;
      mem_fwd_we = 1'b0; mem_fwd_waddr = '0; mem_fwd_wdata = '0;
   endtask

   task automatic issue(input logic [31:0] pc, input logic [31:0] inst);
      if_valid = 1'b1; if_pc = pc; if_inst = inst;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; ex_stall = 1'b0; flush = 1'b0;
      rdata1 = 32'h77; rdata2 = 32'h88;
      quiet_fwd();
      issue(32'h100, 32'h00500093);               // addi x1,x0,5
      check_eq("rst_valid", ex_valid, 0);
      check_eq("rst_pc", ex_pc, 0);
      check_eq("rst_rd_we", ex_rd_we, 0);
      check_eq("rst_ready", id_ready, 0);
      step();
      check_eq("rst_hold_valid", ex_valid, 0);
      rst_n = 1'b1;
      #1;
      check_eq("addi_re1", re1, 1);
      check_eq("addi_raddr1", raddr1, 0);
      check_eq("addi_re2", re2, 0);
      check_eq("addi_ready", id_ready, 1);
      step();
      check_eq("addi_valid", ex_valid, 1);
      check_eq("addi_pc", ex_pc, 32'h100);
      check_eq("addi_op1", ex_op1, 0);
      check_eq("addi_op2", ex_op2, 5);
      check_eq("addi_rd", ex_rd, 1);
      check_eq("addi_rd_we", ex_rd_we, 1);
      check_eq("addi_alu", ex_alu_op, 0);

      // add x3,x1,x2: x1 from EX, x2 from MEM
      ex_fwd_we = 1'b1; ex_fwd_waddr = 5'd1; ex_fwd_wdata = 32'h11;
      mem_fwd_we = 1'b1; mem_fwd_waddr = 5'd2; mem_fwd_wdata = 32'h33;
      issue(32'h104, 32'h002081B3);
      step();
      check_eq("add_op1_ex", ex_op1, 32'h11);
      check_eq("add_op2_mem", ex_op2, 32'h33);
      check_eq("add_rd", ex_rd, 3);
      check_eq("add_alu", ex_alu_op, 4'b0000);

      // same register in EX and MEM: EX wins, x2 falls back to regfile
      mem_fwd_waddr = 5'd1; mem_fwd_wdata = 32'h22;
      issue(32'h108, 32'h002081B3);
      step();
      check_eq("prio_op1", ex_op1, 32'h11);
      check_eq("prio_op2_rf", ex_op2, 32'h88);

      quiet_fwd();
      issue(32'h10C, 32'h402081B3);               // sub x3,x1,x2
      step();
      check_eq("sub_alu", ex_alu_op, 4'b1000);
      check_eq("sub_op1", ex_op1, 32'h77);
      check_eq("sub_op2", ex_op2, 32'h88);

      issue(32'h110, 32'h4030D093);               // srai x1,x1,3
      step();
      check_eq("srai_alu", ex_alu_op, 4'b1101);
      check_eq("srai_op2", ex_op2, 32'h403);

      issue(32'h114, 32'hC0000093);               // addi x1,x0,-1024
      step();
      check_eq("addi_neg_alu", ex_alu_op, 4'b0000);
      check_eq("addi_neg_imm", ex_imm, 32'hFFFFFC00);

      // load-use: lw x1,0(x2) then add x3,x1,x2
      rdata1 = 32'h1000;
      issue(32'h118, 32'h00012083);
      step();
      check_eq("lw_is_load", ex_is_load, 1);
      check_eq("lw_op1", ex_op1, 32'h1000);
      check_eq("lw_rd", ex_rd, 1);
      rdata1 = 32'h77;
      ex_fwd_we = 1'b1; ex_fwd_waddr = 5'd1; ex_fwd_wdata = 32'hBAD; ex_fwd_is_load = 1'b1;
      issue(32'h11C, 32'h002081B3);
      check_eq("lu_ready", id_ready, 0);
      step();
      check_eq("lu_bubble", ex_valid, 0);
      quiet_fwd();
      mem_fwd_we = 1'b1; mem_fwd_waddr = 5'd1; mem_fwd_wdata = 32'hAA;
      #1;
      check_eq("lu_ready2", id_ready, 1);
      step();
      check_eq("lu_valid2", ex_valid, 1);
      check_eq("lu_op1", ex_op1, 32'hAA);
      check_eq("lu_pc", ex_pc, 32'h11C);

      // lui x5,0x12345 ignores a matching load in EX (raddr1 field = 8)
      quiet_fwd();
      ex_fwd_we = 1'b1; ex_fwd_waddr = 5'd8; ex_fwd_is_load = 1'b1;
      issue(32'h120, 32'h123452B7);
      check_eq("lui_re1", re1, 0);
      check_eq("lui_re2", re2, 0);
      check_eq("lui_ready", id_ready, 1);
      step();
      check_eq("lui_op1", ex_op1, 0);
      check_eq("lui_op2", ex_op2, 32'h12345000);
      check_eq("lui_imm", ex_imm, 32'h12345000);
      check_eq("lui_rd", ex_rd, 5);
      quiet_fwd();

      rdata2 = 32'h55;
      issue(32'h124, 32'h0020A423);               // sw x2,8(x1)
      step();
      check_eq("sw_imm", ex_imm, 8);
      check_eq("sw_op2", ex_op2, 8);
      check_eq("sw_data", ex_store_data, 32'h55);
      check_eq("sw_rd_we", ex_rd_we, 0);
      check_eq("sw_is_store", ex_is_store, 1);

      issue(32'h200, 32'h010000EF);               // jal x1,+16
      step();
      check_eq("jal_op1", ex_op1, 32'h200);
      check_eq("jal_op2", ex_op2, 4);
      check_eq("jal_imm", ex_imm, 32'h10);
      check_eq("jal_flag", ex_is_jal, 1);

      // stall holds the register for 3 cycles, then flush wins over stall
      issue(32'h300, 32'h00500093);
      step();
      ex_stall = 1'b1;
      issue(32'h304, 32'h123452B7);
      for (int i = 0; i < 3; i++) begin
         check_eq("stall_ready", id_ready, 0);
         step();
         check_eq("stall_pc", ex_pc, 32'h300);
         check_eq("stall_op2", ex_op2, 5);
      end
      flush = 1'b1;
      #1;
      check_eq("flush_ready", id_ready, 1);
      step();
      check_eq("flush_valid", ex_valid, 0);
      check_eq("flush_rd_we", ex_rd_we, 0);
      flush = 1'b0; ex_stall = 1'b0;

      // forwarding to x0 is ignored
      ex_fwd_we = 1'b1; ex_fwd_waddr = 5'd0; ex_fwd_wdata = 32'hFFFF; rdata1 = 32'hDEAD;
      issue(32'h308, 32'h00500093);
      step();
      check_eq("x0_op1", ex_op1, 0);
      quiet_fwd();

      issue(32'h30C, 32'h0000007F);
      step();
      check_eq("ill_valid", ex_valid, 1);
      check_eq("ill_flag", ex_illegal, 1);
      check_eq("ill_rd_we", ex_rd_we, 0);

      if_valid = 1'b0;
      step();
      check_eq("nv_bubble", ex_valid, 0);

      // reset asserted mid-stall clears immediately
      issue(32'h400, 32'h00500093);
      step();
      ex_stall = 1'b1;
      step();
      check_eq("pre_rst_valid", ex_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_valid", ex_valid, 0);
      check_eq("mid_rst_pc", ex_pc, 0);
      check_eq("mid_rst_ready", id_ready, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
      $finish;
   end

endmodule
